filter_bias_buffer: RTL

//  Filter/bias store directly downstream of the DMA filter/bias path. Captures
//  5x5 filter windows (indexed) and the 120-entry bias vector delivered on the
//  FB_* bus, tracks per-slot validity, and serves one-cycle-latency reads to
//  the convolution engine. Rejects out-of-range writes and reads.

---
 rtl/filter_bias_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/filter_bias_buffer.sv
// Filter/bias store behind the DMA filter/bias path: indexed 5x5 filter slots plus a bias
// vector, with per-slot validity and a one-cycle registered read port for the conv engine.
module filter_bias_buffer #(
  parameter int MAX_FILTERS = 16,
  parameter int NUM_BIAS    = 120,
  parameter int DATA_W      = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                FB_write,
  input  logic                                FB_bias_or_filter,
  input  logic [15:0]                         FB_index_filter,
  input  logic [0:4][0:4][DATA_W-1:0]         FB_filter,
  input  logic [0:NUM_BIAS-1][DATA_W-1:0]     FB_bias,
  input  logic                                rd_req,
  input  logic [15:0]                         rd_filter_index,
  input  logic [15:0]                         rd_bias_index,
  output logic                                rd_valid,
  output logic                                rd_error,
  output logic [0:4][0:4][DATA_W-1:0]         rd_filter,
  output logic [DATA_W-1:0]                   rd_bias,
  output logic                                wr_error,
  output logic [15:0]                         filter_count,
  output logic                                bias_loaded
);
  localparam int FI_W = (MAX_FILTERS > 1) ? $clog2(MAX_FILTERS) : 1;
  localparam int BI_W = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1;

  typedef logic [0:4][0:4][DATA_W-1:0] win_t;

  win_t                   filt_mem [MAX_FILTERS];
  logic [DATA_W-1:0]      bias_mem [NUM_BIAS];
  logic [MAX_FILTERS-1:0] slot_vld;

  // Indices are signed: bit 15 set means negative, hence out of range.
  logic            wr_idx_ok, rd_idx_ok, rd_bidx_ok, rd_ok;
  logic            filt_we, bias_we, new_slot;
  logic [FI_W-1:0] wr_slot, rd_slot;
  logic [BI_W-1:0] rd_bidx;

  assign wr_idx_ok  = !FB_index_filter[15] && (FB_index_filter < 16'(MAX_FILTERS));
  assign rd_idx_ok  = !rd_filter_index[15] && (rd_filter_index < 16'(MAX_FILTERS));
  assign rd_bidx_ok = !rd_bias_index[15]   && (rd_bias_index   < 16'(NUM_BIAS));
  assign wr_slot    = FB_index_filter[FI_W-1:0];
  assign rd_slot    = rd_filter_index[FI_W-1:0];
  assign rd_bidx    = rd_bias_index[BI_W-1:0];

  // clear wins over a coincident write: nothing is stored in that cycle.
  assign filt_we  = FB_write &&  FB_bias_or_filter && wr_idx_ok && !clear;
  assign bias_we  = FB_write && !FB_bias_or_filter && !clear;
  assign new_slot = filt_we && !slot_vld[wr_slot];

  // Validity uses pre-write/pre-clear state, giving read-before-write naturally.
  assign rd_ok = rd_req && rd_idx_ok && rd_bidx_ok && bias_loaded && slot_vld[rd_slot];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_vld <= '0;
      for (int s = 0; s < MAX_FILTERS; s++) filt_mem[s] <= '0;
    end else begin
      if (clear) slot_vld <= '0;
      else if (filt_we) begin
        slot_vld[wr_slot] <= 1'b1;
        filt_mem[wr_slot] <= FB_filter;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bias_loaded <= 1'b0;
      for (int k = 0; k < NUM_BIAS; k++) bias_mem[k] <= '0;
    end else begin
      if (clear) bias_loaded <= 1'b0;
      else if (bias_we) begin
        bias_loaded <= 1'b1;
        for (int k = 0; k < NUM_BIAS; k++) bias_mem[k] <= FB_bias[k];
      end
    end
  end

  // Only first writes to a slot count, so the counter can never exceed MAX_FILTERS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_count <= '0;
      wr_error     <= 1'b0;
    end else begin
      wr_error <= FB_write && FB_bias_or_filter && !wr_idx_ok;
      if (clear)         filter_count <= '0;
      else if (new_slot) filter_count <= filter_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_error  <= 1'b0;
      rd_filter <= '0;
      rd_bias   <= '0;
    end else begin
      rd_valid <= rd_ok;
      rd_error <= rd_req && !rd_ok;
      if (rd_ok) begin
        rd_filter <= filt_mem[rd_slot];
        rd_bias   <= bias_mem[rd_bidx];
      end
    end
  end
endmodule
